// File: rtl/param_calculator.sv
// Parametrised calculator: register file (R0 = 0) feeding an ALU, valid/ready issue, registered result/flags.
// Optional shift-add multiplier on opcode 1101, built only when CALC_MUL_EN is defined.
module param_calculator #(
  parameter  int DATA_W  = 8,
  parameter  int REG_NUM = 8,
  localparam int AW      = $clog2(REG_NUM),
  localparam int SW      = $clog2(DATA_W)
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              WEN,
  input  logic [AW-1:0]     RW,
  input  logic [AW-1:0]     RX,
  input  logic [AW-1:0]     RY,
  input  logic [DATA_W-1:0] DataIn,
  input  logic              Sel,
  input  logic [3:0]        Ctrl,
  output logic [DATA_W-1:0] result,
  output logic              out_valid,
  output logic              Carry,
  output logic              Zero
);

  localparam int MSB = DATA_W - 1;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
    OP_NOT = 4'h4, OP_XOR = 4'h5, OP_NOR = 4'h6, OP_SHL = 4'h7,
    OP_SHR = 4'h8, OP_ASR = 4'h9, OP_ROL = 4'hA, OP_ROR = 4'hB,
    OP_EQ  = 4'hC, OP_MUL = 4'hD
  } op_t;

  logic [DATA_W-1:0] regs [REG_NUM];
  logic [DATA_W-1:0] x, y, alu_res;
  logic [SW-1:0]     sh;
  logic              alu_c;
  logic              accept;
  logic              mul_start;
  logic              mul_done;
  logic [DATA_W-1:0] mul_low;
  logic              mul_high;
  logic              mul_wen;
  logic [AW-1:0]     mul_rw;

  assign accept = in_valid && in_ready;

  // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    x       = Sel ? ((RX == '0) ? '0 : regs[RX]) : DataIn;
    y       = (RY == '0) ? '0 : regs[RY];
    sh      = x[SW-1:0];
    alu_res = '0;
    alu_c   = 1'b0;
    case (op_t'(Ctrl))
      OP_ADD:  {alu_c, alu_res} = {x[MSB], x} + {y[MSB], y};
      OP_SUB:  {alu_c, alu_res} = {x[MSB], x} - {y[MSB], y};
      OP_AND:  alu_res = x & y;
      OP_OR:   alu_res = x | y;
      OP_NOT:  alu_res = ~x;
      OP_XOR:  alu_res = x ^ y;
      OP_NOR:  alu_res = ~(x | y);
      OP_SHL:  alu_res = y << sh;
      OP_SHR:  alu_res = y >> sh;
      OP_ASR:  alu_res = {x[MSB], x[MSB:1]};
      OP_ROL:  alu_res = {x[MSB-1:0], x[MSB]};
      OP_ROR:  alu_res = {x[0], x[MSB:1]};
      OP_EQ:   alu_res = {{(DATA_W-1){1'b0}}, x == y};
      default: alu_res = '0;
    endcase
  end

`ifdef CALC_MUL_EN
  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t              state_q, state_d;
  logic [SW-1:0]       cnt;
  logic [2*DATA_W-1:0] mcand, prod, prod_next;
  logic [DATA_W-1:0]   mplier;

  assign in_ready  = (state_q == S_IDLE);
  assign mul_start = accept && (Ctrl == OP_MUL);
  assign prod_next = prod + (mplier[0] ? mcand : '0);
  assign mul_low   = prod_next[DATA_W-1:0];
  assign mul_high  = |prod_next[2*DATA_W-1:DATA_W];

  always_comb begin
    state_d  = state_q;
    mul_done = 1'b0;
    case (state_q)
      S_IDLE: if (mul_start) state_d = S_MUL;
      S_MUL: begin
        if (cnt == SW'(DATA_W - 1)) begin
          mul_done = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      prod    <= '0;
      mul_wen <= 1'b0;
      mul_rw  <= '0;
    end else begin
      state_q <= state_d;
      if (mul_start) begin
        mcand   <= {{DATA_W{1'b0}}, x};
        mplier  <= y;
        prod    <= '0;
        cnt     <= '0;
        mul_wen <= WEN;
        mul_rw  <= RW;
      end else if (state_q == S_MUL) begin
        prod   <= prod_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
      end
    end
  end
`else
  assign in_ready  = 1'b1;
  assign mul_start = 1'b0;
  assign mul_done  = 1'b0;
  assign mul_low   = '0;
  assign mul_high  = 1'b0;
  assign mul_wen   = 1'b0;
  assign mul_rw    = '0;
`endif

  // NOTE: the register file is reset explicitly because its contents after reset are architecturally visible.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
      result    <= '0;
      Carry     <= 1'b0;
      Zero      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept && !mul_start) begin
        result    <= alu_res;
        Carry     <= alu_c;
        Zero      <= (alu_res == '0);
        out_valid <= 1'b1;
        if (WEN && RW != '0) regs[RW] <= alu_res;
      end else if (mul_done) begin
        result    <= mul_low;
        Carry     <= mul_high;
        Zero      <= (mul_low == '0);
        out_valid <= 1'b1;
        if (mul_wen && mul_rw != '0) regs[mul_rw] <= mul_low;
      end
    end
  end

endmodule

// File: tb/tb_param_calculator.sv
// Self-checking bench for param_calculator (DATA_W=8, REG_NUM=8): directed cases plus random traffic
// compared every cycle against a behavioural model. Multiplier cases run when CALC_MUL_EN is defined.
module tb_param_calculator;

`ifdef CALC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic       clk, rst_n;
  logic       in_valid, in_ready, wen, sel;
  logic [2:0] rw, rx, ry;
  logic [7:0] din, result;
  logic [3:0] ctrl;
  logic       out_valid, carry, zero;

  int checks = 0;
  int errors = 0;

  param_calculator #(.DATA_W(8), .REG_NUM(8)) dut (
    .Clk(clk), .Rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .WEN(wen), .RW(rw), .RX(rx), .RY(ry), .DataIn(din), .Sel(sel), .Ctrl(ctrl),
    .result(result), .out_valid(out_valid), .Carry(carry), .Zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_regs [8];
  int exp_result, exp_carry, exp_zero, exp_ov;
  int mul_left, mul_x, mul_y, mul_rw;
  bit mul_wen;

  function automatic void alu_model(input int op, input int xv, input int yv,
                                    output int r, output int c);
    int sx, sy, s;
    sx = (xv >= 128) ? xv - 256 : xv;
    sy = (yv >= 128) ? yv - 256 : yv;
    c  = 0;
    case (op)
      0:  begin s = sx + sy; r = s & 255; c = (s >> 8) & 1; end
      1:  begin s = sx - sy; r = s & 255; c = (s >> 8) & 1; end
      2:  r = xv & yv;
      3:  r = xv | yv;
      4:  r = (~xv) & 255;
      5:  r = xv ^ yv;
      6:  r = (~(xv | yv)) & 255;
      7:  r = (yv << (xv % 8)) & 255;
      8:  r = yv >> (xv % 8);
      9:  r = (xv >> 1) | (xv & 128);
      10: r = ((xv << 1) | (xv >> 7)) & 255;
      11: r = (xv >> 1) | ((xv & 1) << 7);
      12: r = (xv == yv) ? 1 : 0;
      default: r = 0;
    endcase
  endfunction

  function automatic void retire(input int r, input int c, input bit w, input int dst);
    exp_result = r;
    exp_carry  = c;
    exp_zero   = (r == 0) ? 1 : 0;
    exp_ov     = 1;
    if (w && dst != 0) m_regs[dst] = r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 0;
      exp_result = 0; exp_carry = 0; exp_zero = 0; exp_ov = 0; mul_left = 0;
    end else begin
      int xv, yv, r, c, p;
      exp_ov = 0;
      if (mul_left > 0) begin
        mul_left--;
        if (mul_left == 0) begin
          p = mul_x * mul_y;
          retire(p & 255, (p >> 8) != 0 ? 1 : 0, mul_wen, mul_rw);
        end
      end else if (in_valid) begin
        xv = sel ? m_regs[rx] : int'(din);
        yv = m_regs[ry];
        if (ctrl == 4'hD && MUL_EN) begin
          mul_x = xv; mul_y = yv; mul_wen = wen; mul_rw = int'(rw); mul_left = 8;
        end else begin
          alu_model(int'(ctrl), xv, yv, r, c);
          retire(r, c, wen, int'(rw));
        end
      end
    end
  end

  // Compare process: outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    check("cmp_in_ready",  in_ready,  (mul_left == 0) ? 1 : 0);
    check("cmp_out_valid", out_valid, exp_ov);
    check("cmp_result",    result,    exp_result);
    check("cmp_carry",     carry,     exp_carry);
    check("cmp_zero",      zero,      exp_zero);
  end

  // ---------------- stimulus ----------------
  task automatic issue(input bit w, input int dst, input int sx_reg, input int sy_reg,
                       input bit s, input int op, input int data);
    @(negedge clk);
    in_valid = 1'b1; wen = w; rw = 3'(dst); rx = 3'(sx_reg); ry = 3'(sy_reg);
    sel = s; ctrl = 4'(op); din = 8'(data);
    @(posedge clk);
  endtask

  task automatic settle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic read_reg(input int idx, input int exp, input string name);
    issue(1'b0, 0, idx, idx, 1'b1, 3, 0);
    settle();
    check(name, result, exp);
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; wen = 1'b0; sel = 1'b0;
    rw = '0; rx = '0; ry = '0; din = '0; ctrl = '0;
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_result", result, 0);
    check("rst_carry", carry, 0);
    check("rst_zero", zero, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    for (int i = 0; i < 8; i++) read_reg(i, 0, "rst_reg_read");

    // R1 = 0x7F, then signed-extended ADD/SUB
    issue(1'b1, 1, 0, 0, 1'b0, 0, 8'h7F);
    issue(1'b0, 0, 1, 1, 1'b1, 0, 0);
    settle();
    check("add_r1_r1_result", result, 8'hFE);
    check("add_r1_r1_carry", carry, 0);
    issue(1'b0, 0, 0, 1, 1'b0, 1, 8'h80);
    settle();
    check("sub_result", result, 8'h01);
    check("sub_carry", carry, 1);

    // write to R0 is discarded
    issue(1'b1, 0, 0, 0, 1'b0, 0, 8'h05);
    settle();
    check("r0_write_result", result, 8'h05);
    check("r0_write_out_valid", out_valid, 1);
    read_reg(0, 0, "r0_stays_zero");

    // back-to-back with forwarding through the register file
    issue(1'b1, 2, 0, 0, 1'b0, 0, 8'h0F);
    issue(1'b1, 3, 0, 2, 1'b0, 5, 8'hFF);
    settle();
    check("b2b_result", result, 8'hF0);
    check("b2b_zero", zero, 0);
    read_reg(3, 8'hF0, "b2b_r3");

    if (MUL_EN) begin
      issue(1'b1, 1, 0, 0, 1'b0, 0, 8'h10);
      issue(1'b1, 4, 0, 1, 1'b0, 13, 8'h20);
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        in_valid = 1'b1; ctrl = 4'h0; wen = 1'b1; rw = 3'd6; din = 8'hAA;
        check("mul_busy_ready", in_ready, 0);
      end
      settle();
      check("mul_out_valid", out_valid, 1);
      check("mul_result", result, 8'h00);
      check("mul_carry", carry, 1);
      check("mul_zero", zero, 1);
      read_reg(6, 0, "mul_ignored_issue");
      read_reg(4, 0, "mul_r4");

      // reset asserted in cycle 4 of a multiply
      issue(1'b1, 5, 0, 1, 1'b0, 13, 8'h03);
      settle();
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      check("mul_abort_out_valid", out_valid, 0);
      check("mul_abort_in_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      read_reg(5, 0, "mul_abort_r5");
    end

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 3) != 0);
      wen  = 1'($urandom);
      rw   = 3'($urandom);
      rx   = 3'($urandom);
      ry   = 3'($urandom);
      sel  = 1'($urandom);
      ctrl = 4'($urandom);
      din  = 8'($urandom);
    end
    settle();
    repeat (12) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_calculator.md
Name: param_calculator

Overview:
- Parametrised successor to the 8-bit single-cycle calculator datapath.
- Contains a REG_NUM x DATA_W register file with R0 hard-wired to zero, and a DATA_W ALU whose X operand is muxed between DataIn and a register.
- Adds a valid/ready issue handshake, registered results with status flags, and an optional multi-cycle shift-add multiplier.
- Sits between the instruction sequencer (issue side) and the result consumer.

Parameters:
DATA_W, 8, operand/register width (>=4)
REG_NUM, 8, number of registers (power of 2, >=2); AW = $clog2(REG_NUM)

Ports:
Clk  input  1  clock, rising edge
Rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation presented
in_ready  output  1  block can accept an operation
WEN  input  1  write the result to RW
RW  input  AW  destination register
RX  input  AW  X source register
RY  input  AW  Y source register
DataIn  input  DATA_W  immediate X operand
Sel  input  1  0: X=DataIn; 1: X=reg[RX]
Ctrl  input  4  opcode
result  output  DATA_W  registered ALU result
out_valid  output  1  one-cycle pulse, result/flags updated
Carry  output  1  registered carry/overflow flag
Zero  output  1  registered result==0 flag

Behaviour:
- Reset (Rst_n low, async): all registers 0, result=0, Carry=0, Zero=0, out_valid=0, FSM=IDLE. On exit from reset, in_ready=1.
- Accept: an operation is accepted on a rising edge with in_valid && in_ready. Inputs are ignored at all other times.
- Operands: X = Sel ? reg[RX] : DataIn; Y = reg[RY]. A read of R0 returns 0. Reads are combinational from the current register contents.
- Opcodes, with SH = X[$clog2(DATA_W)-1:0]:
  - 0000 ADD: {C,res} = {X[MSB],X} + {Y[MSB],Y}
  - 0001 SUB: {C,res} = {X[MSB],X} - {Y[MSB],Y}
  - 0010 AND; 0011 OR; 0100 NOT X; 0101 XOR; 0110 NOR
  - 0111 Y<<SH; 1000 Y>>SH (logical)
  - 1001 arithmetic shift right X by 1; 1010 rotate left X by 1; 1011 rotate right X by 1
  - 1100 EQ: res = (X==Y) zero-extended
  - 1101 MUL (see Optional Feature)
  - all others: res = 0
  - C = 0 for every non-ADD/SUB/MUL op (never X).
- Single-cycle ops (FSM stays IDLE): on the accept edge, result, Carry and Zero (result==0) are registered and out_valid=1 for the following cycle. If WEN && RW!=0, reg[RW] is written on the same edge.
  - Latency is 1; back-to-back issue every cycle is allowed.
  - The next op reads the updated register (no hazard).
- FSM states:
  - IDLE: in_ready=1.
  - MUL: in_ready=0; entered on accepting 1101 with the feature enabled.
- Register writes:
  - Writes to R0 are discarded.
  - WEN=0 leaves the register file unchanged.
  - result/Carry/Zero are held between out_valid pulses.
- Reset asserted mid-MUL: the operation is aborted, nothing is written, and the block returns to IDLE.

Optional Feature:
- Macro: CALC_MUL_EN.
- Defined:
  - Opcode 1101 is an unsigned X*Y shift-add multiplier. X, Y, WEN and RW are captured at accept.
  - The FSM spends exactly DATA_W cycles in MUL, one partial-product step per cycle.
  - On the final MUL edge: result = low DATA_W bits; Carry = |high DATA_W bits; Zero = (low==0); reg[RW] is written if WEN && RW!=0; out_valid pulses; FSM returns to IDLE.
  - Accept-to-out_valid latency is DATA_W+1 cycles.
- Undefined: 1101 behaves as a default opcode (single-cycle, res=0, C=0); MUL state and counter are not built.

Test Plan (DATA_W=8, REG_NUM=8):
- Reset with Rst_n=0 mid-cycle, then release -> result=0, Carry=0, Zero=0, out_valid=0, in_ready=1; reading all registers returns 0.
- Write 0x7F to R1 (Sel=0, DataIn=0x7F, Y=R0, ADD, WEN, RW=1), then ADD R1+R1 (Sel=1, RX=RY=1) -> result=0xFE, Carry=0; then SUB DataIn=0x80 minus R1 -> result=0x01, Carry=1.
- ADD DataIn=0x05 with WEN, RW=0, then read R0 -> R0 stays 0; out_valid still pulses with result=0x05.
- Back-to-back: cycle n writes R2=0x0F; cycle n+1 XORs R2 with DataIn=0xFF into R3 -> R3=0xF0, Zero=0, one out_valid per cycle.
- With CALC_MUL_EN: R1=0x10, MUL DataIn=0x20 * R1 -> in_ready low for 8 cycles, result=0x00, Carry=1, Zero=1, out_valid 9 cycles after accept. in_valid asserted during MUL is ignored.
- With CALC_MUL_EN: assert Rst_n low in cycle 4 of a MUL with WEN, RW=5 -> R5=0, FSM=IDLE, no out_valid.
